uart_rx_arbiter: RTL and testbench

Shares one downstream byte sink between NUM_CH independent UART receive channels. Each channel delivers a byte as a one-clock rx_ready pulse with data and frame-error flag. The block buffers one byte per channel and grants pending channels round-robin onto a single valid/ready output stream tagged with the channel index. It flags per-channel overruns when a channel delivers a new byte before its previous byte was forwarded.

---
 rtl/uart_rx_arbiter.sv | 131 +++++++++++++
 tb/tb_uart_rx_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_arbiter.sv
// Round-robin merge of NUM_CH UART receive channels onto one valid/ready byte stream.
// Each channel owns a one-byte holding slot; bytes arriving at a full slot are dropped and flagged.
module uart_rx_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int DATA_BITS = 8,
    parameter int CH_W      = $clog2(NUM_CH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             rx_ready_i,
    input  logic [NUM_CH*DATA_BITS-1:0]   rx_data_i,
    input  logic [NUM_CH-1:0]             rx_error_i,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_BITS-1:0]          out_data,
    output logic [CH_W-1:0]               out_ch,
    output logic                          out_error,
    output logic [NUM_CH-1:0]             overrun,
    input  logic                          overrun_clr
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_e;

    out_state_e                         state_q, state_d;
    logic [NUM_CH-1:0]                  pend_q, pend_d;
    logic [NUM_CH-1:0]                  err_q, err_d;
    logic [NUM_CH-1:0]                  ovr_q, ovr_d;
    logic [NUM_CH-1:0][DATA_BITS-1:0]   slot_q, slot_d;
    logic [NUM_CH-1:0]                  grant, accept, ovr_evt;
    logic [CH_W-1:0]                    last_q, last_d, sel;
    logic [DATA_BITS-1:0]               out_data_q, out_data_d;
    logic [CH_W-1:0]                    out_ch_q, out_ch_d;
    logic                               out_err_q, out_err_d;
    logic                               found, load;

    function automatic logic [CH_W-1:0] rr_index(input logic [CH_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CH_W'(s);
    endfunction

    // The output register may take a new byte when empty or when its byte leaves this cycle.
    assign load = (state_q == EMPTY) || out_ready;

    // Walk backwards so the candidate closest after last_q is the one left standing.
    always_comb begin
        found = 1'b0;
        sel   = last_q;
        for (int i = NUM_CH; i >= 1; i--) begin
            if (pend_q[rr_index(last_q, i)]) begin
                found = 1'b1;
                sel   = rr_index(last_q, i);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
            assign grant[gi]   = load && found && (sel == CH_W'(gi));
            assign accept[gi]  = rx_ready_i[gi] && (!pend_q[gi] || grant[gi]);
            assign ovr_evt[gi] = rx_ready_i[gi] && pend_q[gi] && !grant[gi];
            assign pend_d[gi]  = accept[gi] || (pend_q[gi] && !grant[gi]);
            assign slot_d[gi]  = accept[gi] ? rx_data_i[gi*DATA_BITS +: DATA_BITS] : slot_q[gi];
            assign err_d[gi]   = accept[gi] ? rx_error_i[gi] : err_q[gi];
            assign ovr_d[gi]   = ovr_evt[gi] || (ovr_q[gi] && !overrun_clr);
        end
    endgenerate

    always_comb begin
        out_data_d = out_data_q;
        out_ch_d   = out_ch_q;
        out_err_d  = out_err_q;
        last_d     = last_q;
        if (load && found) begin
            out_data_d = slot_q[sel];
            out_ch_d   = sel;
            out_err_d  = err_q[sel];
            last_d     = sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (found) state_d = FULL;
            FULL:    if (out_ready && !found) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q == FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= '0;
            err_q      <= '0;
            ovr_q      <= '0;
            slot_q     <= '0;
            last_q     <= CH_W'(NUM_CH - 1);
            out_data_q <= '0;
            out_ch_q   <= '0;
            out_err_q  <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            err_q      <= err_d;
            ovr_q      <= ovr_d;
            slot_q     <= slot_d;
            last_q     <= last_d;
            out_data_q <= out_data_d;
            out_ch_q   <= out_ch_d;
            out_err_q  <= out_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_error = out_err_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx_arbiter.sv
// Directed bench for uart_rx_arbiter: per-cycle comparison against a behavioural model
// plus hand-computed expectations on the sequence of accepted beats.
module tb_uart_rx_arbiter;
    localparam int N  = 4;
    localparam int DB = 8;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    rx_ready = '0;
    logic [N*DB-1:0] rx_data = '0;
    logic [N-1:0]    rx_error = '0;
    logic            out_ready = 1'b0;
    logic            overrun_clr = 1'b0;
    logic            out_valid;
    logic [DB-1:0]   out_data;
    logic [CW-1:0]   out_ch;
    logic            out_error;
    logic [N-1:0]    overrun;

    uart_rx_arbiter #(.NUM_CH(N), .DATA_BITS(DB)) dut (
        .clk(clk), .rst(rst),
        .rx_ready_i(rx_ready), .rx_data_i(rx_data), .rx_error_i(rx_error),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_error(out_error),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Behavioural model: a slot per channel, a presented beat, a rotating priority.
    bit          m_valid = 1'b0;
    bit [DB-1:0] m_data = '0;
    bit [CW-1:0] m_ch = '0;
    bit          m_err = 1'b0;
    bit [N-1:0]  m_pend = '0;
    bit [N-1:0]  m_serr = '0;
    bit [N-1:0]  m_ovr = '0;
    bit [DB-1:0] m_sdata [N];
    int          m_last = N - 1;
    int          m_pick;
    int          m_k;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_ch = '0; m_err = 1'b0;
            m_pend = '0; m_serr = '0; m_ovr = '0; m_last = N - 1;
            for (int k = 0; k < N; k++) m_sdata[k] = '0;
        end else begin
            m_pick = -1;
            if (!m_valid || out_ready) begin
                for (int off = 1; off <= N; off++) begin
                    m_k = (m_last + off) % N;
                    if (m_pend[m_k] && m_pick < 0) m_pick = m_k;
                end
                if (m_pick >= 0) begin
                    m_data = m_sdata[m_pick];
                    m_ch   = CW'(m_pick);
                    m_err  = m_serr[m_pick];
                    m_pend[m_pick] = 1'b0;
                    m_last = m_pick;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (overrun_clr) m_ovr = '0;
            for (int k = 0; k < N; k++) begin
                if (rx_ready[k]) begin
                    if (m_pend[k]) m_ovr[k] = 1'b1;
                    else begin
                        m_sdata[k] = rx_data[k*DB +: DB];
                        m_serr[k]  = rx_error[k];
                        m_pend[k]  = 1'b1;
                    end
                end
            end
        end
    end

    logic [10:0] log_q [$];
    logic [10:0] exp_q [$];

    always @(negedge clk) begin
        chk("out_valid", out_valid, m_valid);
        chk("overrun", overrun, m_ovr);
        if (m_valid) begin
            chk("out_data", out_data, m_data);
            chk("out_ch", out_ch, m_ch);
            chk("out_error", out_error, m_err);
        end
        if (out_valid && out_ready && !rst) log_q.push_back({out_error, out_ch, out_data});
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse(input int ch, input logic [DB-1:0] d, input logic e);
        rx_ready[ch] = 1'b1;
        rx_data[ch*DB +: DB] = d;
        rx_error[ch] = e;
    endtask

    task automatic unpulse();
        rx_ready = '0;
        rx_error = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        log_q.delete();
    endtask

    task automatic expect_beat(input int ch, input logic [DB-1:0] d, input logic e);
        exp_q.push_back({e, CW'(ch), d});
    endtask

    task automatic check_log(input string name);
        chk({name, "_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
            chk(name, log_q[i], exp_q[i]);
        exp_q.delete();
    endtask

    int rep;

    initial begin
        tick(2);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_ch", out_ch, 0);
        chk("rst_error", out_error, 0);
        chk("rst_overrun", overrun, 0);
        rst = 1'b0;
        log_q.delete();

        // Single byte with two-clock latency.
        out_ready = 1'b1;
        pulse(2, 8'hA5, 1'b0);
        tick();
        unpulse();
        chk("single_lat0", out_valid, 0);
        tick();
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 8'hA5);
        chk("single_ch", out_ch, 2);
        chk("single_err", out_error, 0);
        tick();
        chk("single_after", out_valid, 0);

        // Simultaneous arrival from reset priority.
        do_reset();
        for (int k = 0; k < N; k++) pulse(k, DB'(8'h10 + k), 1'b0);
        tick();
        unpulse();
        tick(6);
        for (int k = 0; k < N; k++) expect_beat(k, DB'(8'h10 + k), 1'b0);
        check_log("simul");
        chk("simul_pend", m_pend, 0);
        chk("simul_idle", out_valid, 0);

        // Fairness: channels 0 and 3 re-arm when presented, after a grant to ch1.
        do_reset();
        pulse(1, 8'h21, 1'b0);
        tick();
        unpulse();
        tick();
        pulse(0, 8'hC0, 1'b0);
        pulse(3, 8'hC3, 1'b0);
        tick();
        unpulse();
        rep = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid && (out_ch == 2'd0 || out_ch == 2'd3) && rep < 2) begin
                pulse(int'(out_ch), (out_ch == 2'd0) ? 8'hC0 : 8'hC3, 1'b0);
                rep++;
            end
            tick();
            unpulse();
        end
        expect_beat(1, 8'h21, 1'b0);
        expect_beat(3, 8'hC3, 1'b0);
        expect_beat(0, 8'hC0, 1'b0);
        expect_beat(3, 8'hC3, 1'b0);
        expect_beat(0, 8'hC0, 1'b0);
        check_log("fair");

        // Backpressure, overrun, clear with simultaneous set.
        do_reset();
        out_ready = 1'b0;
        pulse(1, 8'h55, 1'b0);
        tick();
        unpulse();
        tick();
        chk("bp_data", out_data, 8'h55);
        pulse(1, 8'h5A, 1'b0);
        tick();
        unpulse();
        pulse(1, 8'h66, 1'b0);
        tick();
        unpulse();
        tick(2);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_data", out_data, 8'h55);
        chk("bp_overrun", overrun, 4'b0010);
        pulse(1, 8'h67, 1'b0);
        overrun_clr = 1'b1;
        tick();
        unpulse();
        overrun_clr = 1'b0;
        chk("bp_set_wins", overrun, 4'b0010);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("bp_cleared", overrun, 0);
        out_ready = 1'b1;
        tick(4);
        expect_beat(1, 8'h55, 1'b0);
        expect_beat(1, 8'h5A, 1'b0);
        check_log("bp");

        // Capture in the same cycle the slot is granted.
        do_reset();
        pulse(0, 8'h01, 1'b0);
        tick();
        pulse(0, 8'h02, 1'b0);
        tick();
        unpulse();
        tick(4);
        expect_beat(0, 8'h01, 1'b0);
        expect_beat(0, 8'h02, 1'b0);
        check_log("cap");
        chk("cap_overrun", overrun, 0);

        // Error passthrough, then reset while a beat is presented and another pending.
        do_reset();
        out_ready = 1'b0;
        pulse(3, 8'hFF, 1'b1);
        tick();
        unpulse();
        tick();
        chk("err_valid", out_valid, 1);
        chk("err_ch", out_ch, 3);
        chk("err_flag", out_error, 1);
        chk("err_data", out_data, 8'hFF);
        pulse(2, 8'h77, 1'b0);
        tick();
        unpulse();
        rst = 1'b1;
        #1;
        chk("rst_async_valid", out_valid, 0);
        log_q.delete();
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick(5);
        check_log("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
